// File: rtl/ntermo_control.sv
// Game-flow controller for a three-digit guessing game: seeds the secret, sequences per-digit
// comparison against the datapath and writes hint codes. Optional attempt limit: NTERMO_ATTEMPT_LIMIT_EN.
module ntermo_control #(
    parameter int unsigned MAX_TRIES = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       GUESS_VALID,
    output logic       GUESS_READY,
    input  logic       EQ_R0,
    input  logic       EQ_R1,
    input  logic       EQ_R2,
    output logic       RNG_LOAD,
    output logic       H0_ENABLE,
    output logic       H1_ENABLE,
    output logic       H2_ENABLE,
    output logic [1:0] H_SELECT,
    output logic [1:0] N_SELECT,
    output logic [3:0] ATTEMPTS,
    output logic       WIN,
    output logic       LOSE
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEED,
        ST_WAIT_GUESS,
        ST_CMP0,
        ST_CMP1,
        ST_CMP2,
        ST_CMP3,
        ST_CHECK,
        ST_WIN,
        ST_LOSE
    } state_t;

    localparam logic [3:0] TRY_LIMIT = 4'(MAX_TRIES);
`ifdef NTERMO_ATTEMPT_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    state_t     state_reg;
    logic       guess_ready_reg;
    logic       rng_load_reg;
    logic       win_reg;
    logic       lose_reg;
    logic [1:0] n_select_reg;
    logic [3:0] attempts_reg;

    logic [2:0] eq_vec;
    logic [2:0] sample_en;
    logic [2:0] h_enable;
    logic [2:0] exact_vec;
    logic [1:0] code_arr [3];
    logic [1:0] h_select_next;
    logic [3:0] attempts_next;
    logic       seed_st;
    logic       limit_hit;

    assign eq_vec        = {EQ_R2, EQ_R1, EQ_R0};
    assign seed_st       = (state_reg == ST_SEED);
    // The datapath registers N_SELECT, so digit k's EQ result arrives one state after it is selected.
    assign sample_en     = {state_reg == ST_CMP3, state_reg == ST_CMP2, state_reg == ST_CMP1};
    assign attempts_next = (attempts_reg == 4'hF) ? 4'hF : attempts_reg + 4'd1;
    assign limit_hit     = LIMIT_EN && (attempts_next == TRY_LIMIT);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            logic [2:0] others;
            logic       exact_bit_reg;

            assign others       = eq_vec & ~(3'b001 << gi);
            assign code_arr[gi] = eq_vec[gi] ? 2'd2 : ((|others) ? 2'd1 : 2'd0);
            assign h_enable[gi] = seed_st | sample_en[gi];
            assign exact_vec[gi] = exact_bit_reg;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    exact_bit_reg <= 1'b0;
                end else if (sample_en[gi]) begin
                    exact_bit_reg <= eq_vec[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        h_select_next = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (sample_en[k]) begin
                h_select_next = code_arr[k];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg       <= ST_IDLE;
            guess_ready_reg <= 1'b0;
            rng_load_reg    <= 1'b0;
            win_reg         <= 1'b0;
            lose_reg        <= 1'b0;
            n_select_reg    <= 2'd0;
            attempts_reg    <= 4'd0;
        end else begin
            rng_load_reg    <= 1'b0;
            guess_ready_reg <= 1'b0;
            n_select_reg    <= 2'd0;
            case (state_reg)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (START) begin
                        state_reg    <= ST_SEED;
                        rng_load_reg <= 1'b1;
                        attempts_reg <= 4'd0;
                        win_reg      <= 1'b0;
                        lose_reg     <= 1'b0;
                    end
                end
                ST_SEED: begin
                    state_reg       <= ST_WAIT_GUESS;
                    guess_ready_reg <= 1'b1;
                end
                ST_WAIT_GUESS: begin
                    if (GUESS_VALID && guess_ready_reg) begin
                        state_reg    <= ST_CMP0;
                        n_select_reg <= 2'd3;
                    end else begin
                        guess_ready_reg <= 1'b1;
                    end
                end
                ST_CMP0: begin
                    state_reg    <= ST_CMP1;
                    n_select_reg <= 2'd2;
                end
                ST_CMP1: begin
                    state_reg    <= ST_CMP2;
                    n_select_reg <= 2'd1;
                end
                ST_CMP2: begin
                    state_reg <= ST_CMP3;
                end
                ST_CMP3: begin
                    state_reg <= ST_CHECK;
                end
                ST_CHECK: begin
                    attempts_reg <= attempts_next;
                    if (&exact_vec) begin
                        state_reg <= ST_WIN;
                        win_reg   <= 1'b1;
                    end else if (limit_hit) begin
                        state_reg <= ST_LOSE;
                        lose_reg  <= 1'b1;
                    end else begin
                        state_reg       <= ST_WAIT_GUESS;
                        guess_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign GUESS_READY = guess_ready_reg;
    assign RNG_LOAD    = rng_load_reg;
    assign H0_ENABLE   = h_enable[0];
    assign H1_ENABLE   = h_enable[1];
    assign H2_ENABLE   = h_enable[2];
    assign H_SELECT    = h_select_next;
    assign N_SELECT    = n_select_reg;
    assign ATTEMPTS    = attempts_reg;
    assign WIN         = win_reg;
    assign LOSE        = lose_reg;

endmodule

// File: doc/ntermo_control.md
NTERMO_CONTROL -- requirements
Module: ntermo_control

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 6, maximum guesses per game (legal 1..15).
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port START  input  1  new-game request.
REQ-005 SHALL have port GUESS_VALID  input  1  player guess N0..N2 presented.
REQ-006 SHALL have port GUESS_READY  output  1  controller can accept a guess.
REQ-007 SHALL have ports EQ_R0, EQ_R1, EQ_R2  input  1 each  secret digit k equals the currently compared guess digit, from the datapath.
REQ-008 SHALL have port RNG_LOAD  output  1  capture the secret into the datapath.
REQ-009 SHALL have ports H0_ENABLE, H1_ENABLE, H2_ENABLE  output  1 each  hint register write enables.
REQ-010 SHALL have port H_SELECT  output  2  hint code: 0 absent (00), 1 misplaced (01), 2 exact (10); 3 never driven.
REQ-011 SHALL have port N_SELECT  output  2  guess digit to compare: 3 N0, 2 N1, 1 N2, 0 none.
REQ-012 SHALL have port ATTEMPTS  output  4  guesses evaluated this game.
REQ-013 SHALL have ports WIN, LOSE  output  1 each  game-over flags.

Function
REQ-014 SHALL implement states IDLE, SEED, WAIT_GUESS, CMP0, CMP1, CMP2, CMP3, CHECK, WIN, LOSE.
REQ-015 SHALL honour START only in IDLE, WIN and LOSE; START in any other state is ignored.
REQ-016 SHALL, in SEED (one cycle), assert RNG_LOAD and all three H*_ENABLE with H_SELECT=0, clear ATTEMPTS and WIN/LOSE, then go to WAIT_GUESS.
REQ-017 SHALL assert GUESS_READY only in WAIT_GUESS; a guess is accepted on a cycle with GUESS_VALID and GUESS_READY both high; the environment holds N0..N2 stable until GUESS_READY reasserts or the game ends.
REQ-018 SHALL drive N_SELECT 3, 2, 1, 0 in CMP0, CMP1, CMP2, CMP3 respectively, and 0 in every other state.
REQ-019 SHALL account for the one-cycle N_SELECT register in the datapath: EQ inputs are sampled for digit k one state after that digit's N_SELECT, i.e. digit 0 in CMP1, digit 1 in CMP2, digit 2 in CMP3.
REQ-020 SHALL, when sampling digit k, assert Hk_ENABLE for that single cycle with H_SELECT=2 if EQ_Rk, else 1 if any other EQ_Rj, else 0; no duplicate-digit counting.
REQ-021 SHALL latch a per-digit exact flag in CMP1..CMP3 and ignore EQ inputs in every other state.
REQ-022 SHALL, in CHECK, increment ATTEMPTS (saturating at 15), then go to WIN if all three exact flags are set, else to LOSE per REQ-028, else to WAIT_GUESS.
REQ-023 SHALL give a latency of 5 cycles from guess acceptance to GUESS_READY high again (CMP0..CMP3 plus CHECK).
REQ-024 SHALL hold WIN or LOSE high, and GUESS_READY low, in the terminal state until START or RST.
REQ-025 SHALL keep all strobes (RNG_LOAD, H*_ENABLE) single-cycle and never assert two H*_ENABLE simultaneously outside SEED.

Reset
REQ-026 SHALL, while RST is high, place the FSM in IDLE and drive all outputs 0 (ATTEMPTS=0, N_SELECT=0, H_SELECT=0), including when RST is asserted mid-comparison.
REQ-027 SHALL leave IDLE only on START after RST deasserts.

Configuration
REQ-028 SHALL, with macro NTERMO_ATTEMPT_LIMIT_EN defined, go from CHECK to LOSE when the incremented ATTEMPTS equals MAX_TRIES with no win; without it, LOSE is never entered and play continues until a win, with ATTEMPTS saturating at 15.

Verification
REQ-029 Reset: RST pulse at any state -> all outputs 0 immediately, state IDLE, GUESS_READY 0.
REQ-030 START in IDLE -> RNG_LOAD=1 and H0/H1/H2_ENABLE=1 with H_SELECT=0 for one cycle; GUESS_READY=1 on the next cycle.
REQ-031 Bench datapath model with secret (5,3,1) and guess (5,1,7) -> H0_ENABLE/H_SELECT=2, H1_ENABLE/1, H2_ENABLE/0 on acceptance+2, +3 and +4; ATTEMPTS=1; GUESS_READY at +6.
REQ-032 Secret (5,3,1), guess (5,3,1) -> three H_SELECT=2 writes; WIN=1 after CHECK; ATTEMPTS=1; GUESS_READY stays 0; START then restarts with ATTEMPTS=0.
REQ-033 Macro defined, MAX_TRIES=6, six wrong guesses -> LOSE=1 after the sixth CHECK, ATTEMPTS=6; macro undefined -> GUESS_READY reasserts and a seventh guess is accepted.
REQ-034 START pulsed during CMP1 and GUESS_VALID held high through CHECK -> START ignored; exactly one guess is evaluated per GUESS_READY window.
